// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: takes {mode, rate} commands over a valid/ready port and
// steps an LED pattern (blink, chase, bounce) at a prescaled rate.
module led_pattern_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25,
    parameter int LED_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_rate,
    output logic [LED_W-1:0] led,
    output logic             step,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [1:0]       M_OFF   = 2'd0;
    localparam logic [1:0]       M_BLINK = 2'd1;
    localparam logic [1:0]       M_CHASE = 2'd2;
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       rate_q, rate_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic             accept, tick, adv, flip;

    assign cmd_ready = state_q != LOAD;
    assign accept    = cmd_valid && cmd_ready;
    assign led       = led_q;
    assign step      = step_q;
    assign busy      = state_q == RUN;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rate_d  = rate_q;
        pre_d   = pre_q;
        rcnt_d  = rcnt_q;
        dir_d   = dir_q;
        led_d   = led_q;
        step_d  = 1'b0;
        tick    = 1'b0;
        adv     = 1'b0;
        // bounce reverses when the lit bit sits on the end it is heading toward
        flip    = dir_q ? led_q[0] : led_q[LED_W-1];
        if (state_q == RUN) begin
            tick   = pre_q == PRE_MAX;
            pre_d  = tick ? '0 : pre_q + 1'b1;
            adv    = tick && (rcnt_q == rate_q);
            rcnt_d = !tick ? rcnt_q : adv ? '0 : rcnt_q + 1'b1;
            if (adv) begin
                step_d = 1'b1;
                dir_d  = (mode_q == M_CHASE || mode_q == M_BLINK) ? dir_q : dir_q ^ flip;
                led_d  = (mode_q == M_BLINK) ? ~led_q :
                         (mode_q == M_CHASE) ? {led_q[LED_W-2:0], led_q[LED_W-1]} :
                         (dir_q == flip)     ? led_q << 1 : led_q >> 1;
            end
        end
        if (state_q == LOAD) begin
            pre_d   = '0;
            rcnt_d  = '0;
            dir_d   = 1'b0;
            led_d   = (mode_q == M_OFF) ? '0 : (mode_q == M_BLINK) ? '1 : LED_W'(1);
            state_d = (mode_q == M_OFF) ? IDLE : RUN;
        end
        if (accept) begin
            mode_d  = cmd_mode;
            rate_d  = cmd_rate;
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            rate_q  <= '0;
            pre_q   <= '0;
            rcnt_q  <= '0;
            dir_q   <= 1'b0;
            led_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            pre_q   <= pre_d;
            rcnt_q  <= rcnt_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            step_q  <= step_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: scoreboard bench; expected step values and cycles are
// queued when a command is sent and checked on every step pulse.
module tb_led_pattern_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [3:0] cmd_rate = 4'd0;
    logic [7:0] led;
    logic       step;
    logic       busy;

    typedef struct {
        logic [7:0] led;
        int         cyc;
        bit         oh;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   a;

    led_pattern_ctrl #(.TICK_DIV(4), .CNT_W(3), .LED_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_rate(cmd_rate), .led(led), .step(step), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (step) begin
            chk("step_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("step_led", led, e.led);
                chk("step_cyc", cyc, e.cyc);
                if (e.oh) chk("bounce_onehot", $countones(led), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] r, output int acc);
        chk("ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_rate  = r;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic push_run(input int mode, input int rate, input int acc, input int n);
        int   p = 0;
        int   d = 1;
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            if (mode == 1) e.led = (k % 2 == 1) ? 8'h00 : 8'hFF;
            else if (mode == 2) e.led = 8'(1 << (k % 8));
            else begin
                if (p + d < 0 || p + d > 7) d = -d;
                p = p + d;
                e.led = 8'(1 << p);
            end
            e.cyc = acc + 1 + k * (rate + 1) * 4;
            e.oh  = (mode == 3);
            sb.push_back(e);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("led_in_reset", led, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("idle_led", led, 8'h00);
            chk("idle_busy", busy, 0);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_step", step, 0);
        end

        send(2'd1, 4'd0, a);
        chk("load_ready", cmd_ready, 0);
        chk("load_busy", busy, 0);
        push_run(1, 0, a, 4);
        tick();
        chk("blink_load_led", led, 8'hFF);
        chk("blink_busy", busy, 1);
        wait_empty();

        send(2'd2, 4'd1, a);
        push_run(2, 1, a, 8);
        tick();
        chk("chase_load_led", led, 8'h01);
        wait_empty();

        send(2'd3, 4'd0, a);
        push_run(3, 0, a, 16);
        tick();
        chk("bounce_load_led", led, 8'h01);
        wait_empty();

        send(2'd2, 4'd0, a);
        push_run(2, 0, a, 4);
        wait_empty();
        chk("chase_at_10", led, 8'h10);
        send(2'd0, 4'd0, a);
        chk("off_load_ready", cmd_ready, 0);
        tick();
        chk("off_led", led, 8'h00);
        chk("off_busy", busy, 0);
        chk("off_ready", cmd_ready, 1);
        repeat (10) tick();
        chk("off_hold_led", led, 8'h00);

        send(2'd3, 4'd0, a);
        push_run(3, 0, a, 5);
        wait_empty();
        chk("bounce_at_20", led, 8'h20);
        rst = 1'b1;
        tick();
        chk("rst_led", led, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b0;

        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        cmd_rate  = 4'd1;
        tick();
        a = cyc;
        chk("hold_load_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        chk("hold_led", led, 8'hFF);
        push_run(1, 1, a, 2);
        for (int i = 0; i < 4; i++) begin
            chk("hold_single_accept", cmd_ready, 1);
            tick();
        end
        wait_empty();

        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        cmd_rate  = 4'd0;
        tick();
        cmd_mode  = 2'd2;
        tick();
        chk("late_first_led", led, 8'hFF);
        chk("late_ready", cmd_ready, 1);
        tick();
        a = cyc;
        cmd_valid = 1'b0;
        chk("late_accept_ready", cmd_ready, 0);
        push_run(2, 0, a, 3);
        tick();
        chk("late_load_led", led, 8'h01);
        wait_empty();

        send(2'd0, 4'd0, a);
        tick();
        chk("final_off_led", led, 8'h00);
        repeat (12) tick();
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
